scoreboard_hazard_unit: RTL and testbench
=========================================

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 Parameter NREG, default 32: number of architectural registers; register 0 is hard-wired zero.
REQ-002 Parameter LAT_W, default 4: width of producer latency field and per-register countdown counters.
REQ-003 Parameter BR_EXTRA, default 1: extra cycles an ID-stage consumer (branch/jalr compare in ID) waits beyond an EX-stage consumer.
REQ-004 Parameter PERF_W, default 32: width of stall performance counter.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 rs1_id, rs2_id  in  $clog2(NREG) each  source registers of instruction in ID.
REQ-009 rs1_used, rs2_used  in  1 each  source actually read by ID instruction.
REQ-010 is_branch_id  in  1  ID instruction resolves in ID (branch or jalr).
REQ-011 wr_en_id, rd_id, lat_id  in  1 / $clog2(NREG) / LAT_W  ID instruction writes rd; lat_id = cycles after EX until result is forwardable (0 ALU, 1 load, N mul/div).
REQ-012 control_bubble  in  1  flush request: squash ID instruction.
REQ-013 mem_stall  in  1  global freeze from variable-latency memory.
REQ-014 PCWrite, IF_IDWrite, ID_EXWrite  out  1 each  pipeline register enables.
REQ-015 ControlSrc  out  1  1 = pass decoded control into ID/EX, 0 = insert bubble.
REQ-016 busy  out  1  any scoreboard counter nonzero.
REQ-017 stall_count  out  PERF_W  saturating count of hazard-stall cycles.

Function
REQ-018 Block SHALL hold cnt[r] (LAT_W bits) per register r = 1..NREG-1; cnt[0] SHALL read as 0 always.
REQ-019 Hazard on a used source rs SHALL be: rs != 0 and (cnt[rs] > BR_EXTRA when is_branch_id=0, cnt[rs] > 0 when is_branch_id=1); stall = hazard on rs1 or rs2.
REQ-020 Output priority SHALL be: mem_stall > stall > control_bubble > normal.
REQ-021 mem_stall=1: PCWrite=0, IF_IDWrite=0, ID_EXWrite=0, ControlSrc=1; all counters hold; no issue.
REQ-022 stall=1 (mem_stall=0): PCWrite=0, IF_IDWrite=0, ID_EXWrite=1, ControlSrc=0; no issue.
REQ-023 control_bubble=1 (no stall): PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, ControlSrc=0; no issue.
REQ-024 Normal: all enables 1, ControlSrc=1; issue = wr_en_id and rd_id != 0.
REQ-025 Outputs PCWrite/IF_IDWrite/ID_EXWrite/ControlSrc SHALL be combinational from inputs and cnt, same cycle.
REQ-026 Each clock without mem_stall, every nonzero cnt SHALL decrement by 1, saturating at 0.
REQ-027 On issue, cnt[rd_id] next SHALL be max(cnt[rd_id]-1 saturated, lat_id+BR_EXTRA) (WAW keeps the later completion).
REQ-028 lat_id+BR_EXTRA SHALL saturate at 2^LAT_W-1.
REQ-029 busy SHALL be registered-state derived: 1 iff any cnt nonzero.
REQ-030 stall_count SHALL increment on each cycle with stall=1 and mem_stall=0, saturating at all ones.

Reset
REQ-031 reset=1 at a clock edge SHALL clear all cnt and stall_count to 0, regardless of mem_stall or issue in that cycle.
REQ-032 While reset=1, outputs SHALL be PCWrite=1, IF_IDWrite=1, ID_EXWrite=1, ControlSrc=1, busy=0.
REQ-033 Reset mid-operation (counters nonzero) SHALL discard all pending entries; first post-reset ID instruction SHALL see no hazard.

Verification (BR_EXTRA=1, LAT_W=4)
REQ-034 Load x5 (lat 1) issued, next ID add reads x5 -> exactly 1 stall cycle (ControlSrc=0, PCWrite=0), then issue; stall_count=1.
REQ-035 Load x5 issued, next ID beq reads x5 -> 2 stall cycles; ALU x6 (lat 0) then beq reads x6 -> 1 stall; ALU x6 then add reads x6 -> 0 stalls.
REQ-036 Div x7 lat 8 issued, mem_stall=1 for 3 cycles during countdown -> counter frozen, dependent add stalls 8 hazard cycles total, stall_count=8, frozen cycles not counted.
REQ-037 Div x7 lat 8 then load x7 issued next cycle -> cnt[x7] stays 8 (max rule), not 2; rd_id=0 with lat 8 -> no entry, busy unchanged.
REQ-038 control_bubble=1 with wr_en_id=1 rd x9 lat 5 -> ControlSrc=0, enables 1, cnt[x9] stays 0; reset asserted with cnt[x7]=6 -> next cycle busy=0, stall_count=0.

Source files
------------

// File: rtl/scoreboard_hazard_unit.sv
// Scoreboard-based hazard detection for an in-order pipeline.
// Each architectural register carries a countdown of cycles until its pending
// result becomes forwardable. The ID instruction stalls while one of its
// sources is still counting down. Branch/jalr compares in ID need the result
// BR_EXTRA cycles earlier than EX consumers, so they see a lower threshold.
module scoreboard_hazard_unit #(
  parameter int NREG     = 32,
  parameter int LAT_W    = 4,
  parameter int BR_EXTRA = 1,
  parameter int PERF_W   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [$clog2(NREG)-1:0] rs1_id,
  input  logic [$clog2(NREG)-1:0] rs2_id,
  input  logic                    rs1_used,
  input  logic                    rs2_used,
  input  logic                    is_branch_id,
  input  logic                    wr_en_id,
  input  logic [$clog2(NREG)-1:0] rd_id,
  input  logic [LAT_W-1:0]        lat_id,
  input  logic                    control_bubble,
  input  logic                    mem_stall,
  output logic                    PCWrite,
  output logic                    IF_IDWrite,
  output logic                    ID_EXWrite,
  output logic                    ControlSrc,
  output logic                    busy,
  output logic [PERF_W-1:0]       stall_count
);

  localparam int RW      = $clog2(NREG);
  localparam int LAT_MAX = (1 << LAT_W) - 1;

  // Register 0 is hard-wired zero, so it owns no counter at all.
  logic [LAT_W-1:0]  cnt_q [1:NREG-1];
  logic [LAT_W-1:0]  cnt_d [1:NREG-1];
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [LAT_W-1:0] cnt_rs1, cnt_rs2;
  logic             haz_rs1, haz_rs2, stall;
  logic [31:0]      lat_sum;
  logic [LAT_W-1:0] lat_sat;
  logic             issue;
  logic             any_pending;

  // Look up the pending counts of both sources; x0 and out-of-range ids read 0.
  always_comb begin
    cnt_rs1 = '0;
    cnt_rs2 = '0;
    for (int r = 1; r < NREG; r++) begin
      if (rs1_id == RW'(r)) cnt_rs1 = cnt_q[r];
      if (rs2_id == RW'(r)) cnt_rs2 = cnt_q[r];
    end
  end

  // Hazard detection: ID-stage consumers need the value BR_EXTRA cycles sooner.
  always_comb begin
    haz_rs1 = rs1_used && (is_branch_id ? (cnt_rs1 != '0)
                                        : (32'(cnt_rs1) > 32'(BR_EXTRA)));
    haz_rs2 = rs2_used && (is_branch_id ? (cnt_rs2 != '0)
                                        : (32'(cnt_rs2) > 32'(BR_EXTRA)));
    stall   = haz_rs1 || haz_rs2;
  end

  // Countdown loaded on issue, saturated to the counter width.
  always_comb begin
    lat_sum = 32'(lat_id) + 32'(BR_EXTRA);
    lat_sat = (lat_sum > 32'(LAT_MAX)) ? '1 : lat_sum[LAT_W-1:0];
  end

  // Pipeline enables by priority: reset, memory freeze, hazard, flush, normal.
  always_comb begin
    PCWrite    = 1'b1;
    IF_IDWrite = 1'b1;
    ID_EXWrite = 1'b1;
    ControlSrc = 1'b1;
    issue      = 1'b0;
    if (!reset) begin
      if (mem_stall) begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        ID_EXWrite = 1'b0;
      end else if (stall) begin
        PCWrite    = 1'b0;
        IF_IDWrite = 1'b0;
        ControlSrc = 1'b0;
      end else if (control_bubble) begin
        ControlSrc = 1'b0;
      end else begin
        issue = wr_en_id && (rd_id != '0);
      end
    end
  end

  // Counter next state: decrement unless frozen; an issue keeps the later of
  // the old completion and the new one (write-after-write).
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!mem_stall && cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - 1'b1;
      if (issue && rd_id == RW'(r) && lat_sat > cnt_d[r]) cnt_d[r] = lat_sat;
    end
    stall_cnt_d = stall_cnt_q;
    if (!mem_stall && stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  // State registers with synchronous reset that discards all pending entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 1; r < NREG; r++) cnt_q[r] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy reflects registered counter state only, forced low while in reset.
  always_comb begin
    any_pending = 1'b0;
    for (int r = 1; r < NREG; r++) any_pending = any_pending | (cnt_q[r] != '0);
    busy        = any_pending && !reset;
    stall_count = stall_cnt_q;
  end

endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// Testbench for scoreboard_hazard_unit (default parameters).
// Reference model tracks, per register, the absolute "unfrozen time" at which
// its result becomes usable; remaining wait is derived from that timestamp.
module tb_scoreboard_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        rs1_used, rs2_used, is_branch_id, wr_en_id;
  logic [3:0]  lat_id;
  logic        control_bubble, mem_stall;
  logic        PCWrite, IF_IDWrite, ID_EXWrite, ControlSrc, busy;
  logic [31:0] stall_count;
  logic [3:0]  ctl;

  int total = 0;
  int bad   = 0;

  // Model state: time advances only on cycles that are not frozen.
  int unsigned tnow = 0;
  int unsigned ready [32];
  int unsigned m_sc = 0;

  scoreboard_hazard_unit dut (
    .clk(clk), .reset(reset),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .is_branch_id(is_branch_id),
    .wr_en_id(wr_en_id), .rd_id(rd_id), .lat_id(lat_id),
    .control_bubble(control_bubble), .mem_stall(mem_stall),
    .PCWrite(PCWrite), .IF_IDWrite(IF_IDWrite), .ID_EXWrite(ID_EXWrite),
    .ControlSrc(ControlSrc), .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;
  assign ctl = {PCWrite, IF_IDWrite, ID_EXWrite, ControlSrc};

  function automatic int unsigned rem(input int r);
    if (r == 0) return 0;
    return (ready[r] > tnow) ? ready[r] - tnow : 0;
  endfunction

  function automatic bit m_hazard();
    int unsigned thr;
    thr = is_branch_id ? 0 : 1;
    return (rs1_used && rem(int'(rs1_id)) > thr) || (rs2_used && rem(int'(rs2_id)) > thr);
  endfunction

  function automatic logic [3:0] m_ctrl();
    if (reset)          return 4'b1111;
    if (mem_stall)      return 4'b0001;
    if (m_hazard())     return 4'b0010;
    if (control_bubble) return 4'b1110;
    return 4'b1111;
  endfunction

  function automatic logic m_busy();
    logic b;
    b = 1'b0;
    for (int r = 1; r < 32; r++) if (rem(r) > 0) b = 1'b1;
    return b && !reset;
  endfunction

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    int unsigned l;
    if (reset) begin
      for (int r = 0; r < 32; r++) ready[r] = 0;
      m_sc = 0;
    end else if (!mem_stall) begin
      if (m_hazard()) begin
        if (m_sc != 32'hFFFF_FFFF) m_sc++;
      end else if (!control_bubble && wr_en_id && rd_id != 0) begin
        l = int'(lat_id) + 1;
        if (l > 15) l = 15;
        if (tnow + 1 + l > ready[rd_id]) ready[rd_id] = tnow + 1 + l;
      end
      tnow++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rs1_used = 0; rs2_used = 0; is_branch_id = 0;
    wr_en_id = 0; rd_id = 0; lat_id = 0; control_bubble = 0; mem_stall = 0;
    reset = 0;
  endtask

  task automatic set_instr(input int s1, input bit u1, input int s2, input bit u2,
                           input bit br, input bit we, input int rd, input int lat);
    rs1_id = 5'(s1); rs1_used = u1; rs2_id = 5'(s2); rs2_used = u2;
    is_branch_id = br; wr_en_id = we; rd_id = 5'(rd); lat_id = 4'(lat);
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Clock through hazard-stall cycles plus the issuing cycle; n = stall cycles.
  task automatic count_stalls(output int n);
    bit done;
    n = 0;
    done = 0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (ControlSrc == 1'b0 && PCWrite == 1'b0) n++;
      else done = 1;
      tick();
    end
    if (!done) n = 999;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    set_instr(3, 1, 4, 1, 1, 1, 5, 3);
    mem_stall = 1;
    @(negedge clk);
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL reset_ctrl got=%b want=1111", ctl); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    tick();
    idle();
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b want=0", busy); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL post_reset_sc got=%0d want=0", stall_count); end
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL post_reset_ctrl got=%b want=1111", ctl); end
  endtask

  task automatic test_load_use();
    int n;
    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 5, 1);
    tick();
    set_instr(5, 1, 0, 0, 0, 1, 10, 0);
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL load_use_stalls got=%0d want=1", n); end
    idle();
    @(negedge clk);
    total++; if (stall_count !== 32'd1) begin bad++; $display("FAIL load_use_sc got=%0d want=1", stall_count); end
  endtask

  task automatic test_branch();
    int n;
    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 5, 1);
    tick();
    set_instr(5, 1, 0, 0, 1, 0, 0, 0);
    count_stalls(n);
    total++; if (n != 2) begin bad++; $display("FAIL load_beq_stalls got=%0d want=2", n); end
    idle();
    @(negedge clk);
    total++; if (stall_count !== 32'd2) begin bad++; $display("FAIL load_beq_sc got=%0d want=2", stall_count); end

    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 6, 0);
    tick();
    set_instr(0, 0, 6, 1, 1, 0, 0, 0);
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL alu_beq_stalls got=%0d want=1", n); end

    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 6, 0);
    tick();
    set_instr(0, 0, 6, 1, 0, 1, 12, 0);
    count_stalls(n);
    total++; if (n != 0) begin bad++; $display("FAIL alu_add_stalls got=%0d want=0", n); end
  endtask

  task automatic test_mem_stall_div();
    int  n;
    bit  done;
    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 7, 8);
    tick();
    set_instr(7, 1, 0, 0, 0, 1, 11, 0);
    n = 0;
    done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      mem_stall = (k >= 2 && k < 5);
      @(negedge clk);
      if (mem_stall) begin
        total++; if (ctl !== 4'b0001) begin bad++; $display("FAIL mem_freeze_ctrl got=%b want=0001", ctl); end
      end else if (ControlSrc == 1'b0) n++;
      else done = 1;
      tick();
    end
    total++; if (!done) begin bad++; $display("FAIL div_timeout got=not_issued want=issued"); end
    total++; if (n != 8) begin bad++; $display("FAIL div_stalls got=%0d want=8", n); end
    idle();
    @(negedge clk);
    total++; if (stall_count !== 32'd8) begin bad++; $display("FAIL div_sc got=%0d want=8", stall_count); end
  endtask

  task automatic test_waw_rd0();
    int n;
    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 7, 8);
    tick();
    set_instr(0, 0, 0, 0, 0, 1, 7, 1);
    tick();
    set_instr(7, 1, 0, 0, 0, 0, 0, 0);
    count_stalls(n);
    total++; if (n != 7) begin bad++; $display("FAIL waw_stalls got=%0d want=7", n); end

    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 0, 8);
    tick();
    set_instr(0, 1, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rd0_busy got=%b want=0", busy); end
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL x0_read_ctrl got=%b want=1111", ctl); end
  endtask

  task automatic test_bubble_reset();
    int n;
    do_reset();
    set_instr(0, 0, 0, 0, 0, 1, 9, 5);
    control_bubble = 1;
    @(negedge clk);
    total++; if (ctl !== 4'b1110) begin bad++; $display("FAIL bubble_ctrl got=%b want=1110", ctl); end
    tick();
    idle();
    set_instr(9, 1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bubble_busy got=%b want=0", busy); end
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL bubble_no_entry got=%b want=1111", ctl); end
    tick();

    set_instr(0, 0, 0, 0, 0, 1, 3, 1);
    tick();
    set_instr(3, 1, 0, 0, 0, 1, 7, 5);
    count_stalls(n);
    total++; if (n != 1) begin bad++; $display("FAIL pre_reset_stalls got=%0d want=1", n); end
    reset = 1;
    mem_stall = 1;
    set_instr(7, 1, 7, 1, 1, 1, 8, 8);
    @(negedge clk);
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL mid_reset_ctrl got=%b want=1111", ctl); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b want=0", busy); end
    tick();
    reset = 0;
    mem_stall = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL after_reset_busy got=%b want=0", busy); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL after_reset_sc got=%0d want=0", stall_count); end
    total++; if (ctl !== 4'b1111) begin bad++; $display("FAIL after_reset_hazard got=%b want=1111", ctl); end
    tick();
  endtask

  task automatic test_random();
    logic [3:0] e_ctl;
    logic       e_busy;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rs1_id         = 5'($urandom_range(0, 7));
      rs2_id         = 5'($urandom_range(0, 7));
      rs1_used       = 1'($urandom_range(0, 1));
      rs2_used       = 1'($urandom_range(0, 1));
      is_branch_id   = ($urandom_range(0, 3) == 0);
      wr_en_id       = ($urandom_range(0, 3) != 0);
      rd_id          = 5'($urandom_range(0, 7));
      lat_id         = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                   : 4'($urandom_range(0, 3));
      control_bubble = ($urandom_range(0, 7) == 0);
      mem_stall      = ($urandom_range(0, 7) == 0);
      reset          = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      e_ctl  = m_ctrl();
      e_busy = m_busy();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", c, ctl, e_ctl); end
      total++; if (busy !== e_busy) begin bad++; $display("FAIL rand_busy cyc=%0d got=%b want=%b", c, busy, e_busy); end
      total++; if (stall_count !== m_sc) begin bad++; $display("FAIL rand_sc cyc=%0d got=%0d want=%0d", c, stall_count, m_sc); end
      tick();
    end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) ready[r] = 0;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall_div();
    test_waw_rd0();
    test_bubble_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
